dmem_bridge: RTL and testbench

- Sits between the single-cycle core's data-memory port and a valid/ready memory bus, downstream of the core.
- Turns each core load/store into one bus transaction: word-aligned address, byte strobes, lane-replicated write data.
- Holds the core with `stall` until the transaction completes, then returns sign- or zero-extended load data.
- Misaligned or illegal accesses and bus timeouts end in a one-cycle error pulse; misaligned or illegal accesses never reach the bus.

---
 rtl/dmem_bridge.sv | 156 +++++++++++++++
 tb/tb_dmem_bridge.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bridge.sv
// dmem_bridge: turns single-cycle core loads/stores into valid/ready bus transactions,
// stalling the core until the access completes, is rejected, or times out.
`default_nettype none

module dmem_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_rd,
  input  logic        dmem_wr,
  input  logic [31:0] dmem_addr,
  input  logic [2:0]  dmem_size,
  input  logic [31:0] dmem_data_out,
  output logic [31:0] dmem_data_in,
  output logic        stall,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rdata,
  output logic        misalign,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  size_q;
  logic [1:0]  lane_q;

  logic [1:0]  lane;
  logic        req;
  logic        legal_size;
  logic        aligned;
  logic        illegal;
  logic [3:0]  strb;
  logic [31:0] wdata;

  assign lane  = dmem_addr[1:0];
  assign req   = dmem_rd ^ dmem_wr;
  assign stall = (dmem_rd | dmem_wr) && (state != DONE) && rst;

  always_comb begin
    legal_size = 1'b1;
    aligned    = 1'b1;
    strb       = 4'b0000;
    wdata      = dmem_data_out;
    case (dmem_size)
      3'b000, 3'b100: begin
        strb  = 4'b0001 << lane;
        wdata = {4{dmem_data_out[7:0]}};
      end
      3'b001, 3'b101: begin
        aligned = ~dmem_addr[0];
        strb    = 4'b0011 << lane;
        wdata   = {2{dmem_data_out[15:0]}};
      end
      3'b010: begin
        aligned = (lane == 2'b00);
        strb    = 4'b1111;
      end
      default: legal_size = 1'b0;
    endcase
    illegal = (dmem_rd & dmem_wr) | (req & ~(legal_size & aligned));
  end

  // Halfword lanes are always 0 or 2 once alignment has been checked, so lane[1] selects the half.
  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] sz,
                                         input logic [1:0] ln);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{ln, 3'b000} +: 8];
    h = w[{ln[1], 4'b0000} +: 16];
    case (sz)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= 16'd0;
      size_q        <= 3'd0;
      lane_q        <= 2'd0;
      bus_req_valid <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= 32'd0;
      bus_wstrb     <= 4'd0;
      bus_wdata     <= 32'd0;
      dmem_data_in  <= 32'd0;
      misalign      <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (illegal) begin
            misalign     <= 1'b1;
            dmem_data_in <= 32'd0;
            state        <= DONE;
          end else if (req) begin
            bus_req_valid <= 1'b1;
            bus_we        <= dmem_wr;
            bus_addr      <= {dmem_addr[31:2], 2'b00};
            bus_wstrb     <= dmem_wr ? strb : 4'b0000;
            bus_wdata     <= wdata;
            size_q        <= dmem_size;
            lane_q        <= lane;
            state         <= REQ;
          end
        end
        REQ: begin
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            cnt           <= 16'd0;
            state         <= RESP;
          end
        end
        RESP: begin
          if (bus_rsp_valid) begin
            dmem_data_in <= bus_we ? 32'd0 : extend(bus_rdata, size_q, lane_q);
            state        <= DONE;
          end else if (cnt == LAST_WAIT) begin
            bus_err      <= 1'b1;
            dmem_data_in <= 32'd0;
            state        <= DONE;
          end else if (cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: directed core accesses against a simple bus responder.
`default_nettype none

module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        dmem_rd, dmem_wr;
  logic [31:0] dmem_addr, dmem_data_out, dmem_data_in;
  logic [2:0]  dmem_size;
  logic        stall, bus_req_valid, bus_req_ready, bus_we, bus_rsp_valid, misalign, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  dmem_bridge #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr),
    .dmem_size(dmem_size), .dmem_data_out(dmem_data_out), .dmem_data_in(dmem_data_in),
    .stall(stall), .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata), .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        chk_wdata;
    int          vcyc;
  } bus_exp_t;

  typedef struct {
    logic [31:0] data;
    logic        mis;
    logic        berr;
    int          stalls;
  } done_exp_t;

  bus_exp_t  bq[$];
  done_exp_t dq[$];

  int          tests = 0;
  int          fails = 0;
  int          ready_delay = 0;
  logic        rsp_enable = 1'b1;
  logic        late_rsp = 1'b0;
  logic [31:0] rsp_word = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus responder: ready after ready_delay valid cycles, response in the cycle after handshake.
  initial begin
    int   waited;
    logic hs;
    waited = 0;
    hs = 1'b0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      bus_rsp_valid = (hs && rsp_enable) || late_rsp;
      bus_rdata     = late_rsp ? 32'h1111_1111 : rsp_word;
      if (bus_req_valid) begin
        bus_req_ready = (waited >= ready_delay);
        waited++;
      end else begin
        bus_req_ready = 1'b0;
        waited = 0;
      end
      @(negedge clk);
      hs = bus_req_valid && bus_req_ready && rst;
    end
  end

  // Monitor: pops expectations on bus handshakes and on core commit cycles.
  initial begin
    int          scnt, vcnt;
    logic        stable;
    logic [68:0] first;
    bus_exp_t    be;
    done_exp_t   de;
    scnt = 0;
    vcnt = 0;
    stable = 1'b1;
    first = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        scnt = 0;
        vcnt = 0;
        continue;
      end
      if (bus_req_valid) begin
        if (vcnt == 0) begin
          first  = {bus_addr, bus_we, bus_wstrb, bus_wdata};
          stable = 1'b1;
        end else if ({bus_addr, bus_we, bus_wstrb, bus_wdata} != first) begin
          stable = 1'b0;
        end
        vcnt++;
        if (bus_req_ready) begin
          if (bq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_bus_req: got addr %h expected no request", bus_addr);
          end else begin
            be = bq.pop_front();
            chk("bus_addr", bus_addr, be.addr);
            chk("bus_we", {31'd0, bus_we}, {31'd0, be.we});
            chk("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, be.strb});
            if (be.chk_wdata) chk("bus_wdata", bus_wdata, be.wdata);
            chk("req_valid_cycles", vcnt, be.vcyc);
            chk("req_fields_stable", {31'd0, stable}, 32'd1);
          end
          vcnt = 0;
        end
      end
      if (dmem_rd || dmem_wr) begin
        if (stall) begin
          scnt++;
        end else begin
          if (dq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_commit: got data %h expected no completion", dmem_data_in);
          end else begin
            de = dq.pop_front();
            chk("load_data", dmem_data_in, de.data);
            chk("misalign", {31'd0, misalign}, {31'd0, de.mis});
            chk("bus_err", {31'd0, bus_err}, {31'd0, de.berr});
            chk("stall_cycles", scnt, de.stalls);
          end
          scnt = 0;
        end
      end else if (misalign || bus_err) begin
        tests++;
        fails++;
        $display("FAIL stray_pulse: got misalign=%b bus_err=%b expected 0", misalign, bus_err);
      end
    end
  end

  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wd, input logic [31:0] rdata,
                        input int rdy_dly, input logic rsp_en, input logic on_bus,
                        input logic [31:0] exp_baddr, input logic [3:0] exp_strb,
                        input logic [31:0] exp_wd, input logic [31:0] exp_data,
                        input logic exp_mis, input logic exp_berr, input int exp_stalls);
    int n;
    ready_delay = rdy_dly;
    rsp_enable  = rsp_en;
    rsp_word    = rdata;
    if (on_bus) bq.push_back('{exp_baddr, wr, exp_strb, exp_wd, wr, rdy_dly + 1});
    dq.push_back('{exp_data, exp_mis, exp_berr, exp_stalls});
    @(posedge clk);
    #1;
    dmem_rd = rd;
    dmem_wr = wr;
    dmem_addr = addr;
    dmem_size = size;
    dmem_data_out = wd;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (!stall) break;
      n++;
    end
    if (n == 40) begin
      tests++;
      fails++;
      $display("FAIL access_timeout: got stall held 40 cycles expected completion at %h", addr);
    end
    @(posedge clk);
    #1;
    dmem_rd = 1'b0;
    dmem_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    dmem_rd = 1'b1;
    dmem_wr = 1'b0;
    dmem_addr = 32'd0;
    dmem_size = 3'b010;
    dmem_data_out = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_req_valid", {31'd0, bus_req_valid}, 32'd0);
    chk("reset_misalign", {31'd0, misalign}, 32'd0);
    chk("reset_bus_err", {31'd0, bus_err}, 32'd0);
    chk("reset_data", dmem_data_in, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    dmem_rd = 1'b0;

    //     rd    wr    addr          size    wdata          rdata          dly rsp  bus   baddr         strb     exp_wdata      exp_data       mis   berr  stalls
    access(1'b1, 1'b0, 32'h0000_0103, 3'b000, 32'h0,        32'h8000_0000, 0, 1'b1, 1'b1, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_FF80, 1'b0, 1'b0, 3);
    access(1'b1, 1'b0, 32'h0000_0103, 3'b100, 32'h0,        32'h8000_0000, 0, 1'b1, 1'b1, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_0080, 1'b0, 1'b0, 3);
    access(1'b0, 1'b1, 32'h0000_0202, 3'b001, 32'h1234_ABCD, 32'h0,        0, 1'b1, 1'b1, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'h0,        1'b0, 1'b0, 3);
    access(1'b1, 1'b0, 32'h0000_0301, 3'b010, 32'h0,        32'h0,         0, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0,        32'h0,         1'b1, 1'b0, 1);
    access(1'b0, 1'b1, 32'h0000_0500, 3'b010, 32'hCAFE_F00D, 32'h0,        3, 1'b1, 1'b1, 32'h0000_0500, 4'b1111, 32'hCAFE_F00D, 32'h0,        1'b0, 1'b0, 6);
    access(1'b1, 1'b0, 32'h0000_0702, 3'b001, 32'h0,        32'h8001_7FFF, 0, 1'b1, 1'b1, 32'h0000_0700, 4'b0000, 32'h0,        32'hFFFF_8001, 1'b0, 1'b0, 3);
    access(1'b1, 1'b0, 32'h0000_0700, 3'b101, 32'h0,        32'h8001_7FFF, 0, 1'b1, 1'b1, 32'h0000_0700, 4'b0000, 32'h0,        32'h0000_7FFF, 1'b0, 1'b0, 3);
    access(1'b0, 1'b1, 32'h0000_0801, 3'b000, 32'h0000_005A, 32'h0,        0, 1'b1, 1'b1, 32'h0000_0800, 4'b0010, 32'h5A5A_5A5A, 32'h0,        1'b0, 1'b0, 3);
    access(1'b1, 1'b1, 32'h0000_0000, 3'b010, 32'h0,        32'h0,         0, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0,        32'h0,         1'b1, 1'b0, 1);
    access(1'b1, 1'b0, 32'h0000_0010, 3'b011, 32'h0,        32'h0,         0, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0,        32'h0,         1'b1, 1'b0, 1);
    // No response: four RESP cycles then bus_err.
    access(1'b1, 1'b0, 32'h0000_0600, 3'b010, 32'h0,        32'h0,         0, 1'b0, 1'b1, 32'h0000_0600, 4'b0000, 32'h0,        32'h0,         1'b0, 1'b1, 6);
    @(negedge clk);
    late_rsp = 1'b1;
    @(negedge clk);
    late_rsp = 1'b0;
    repeat (2) @(negedge clk);
    access(1'b1, 1'b0, 32'h0000_0404, 3'b010, 32'h0,        32'h2222_2222, 0, 1'b1, 1'b1, 32'h0000_0404, 4'b0000, 32'h0,        32'h2222_2222, 1'b0, 1'b0, 3);

    // Reset asserted in the first RESP cycle of a load that never gets a response.
    ready_delay = 0;
    rsp_enable = 1'b0;
    bq.push_back('{32'h0000_0900, 1'b0, 4'b0000, 32'h0, 1'b0, 1});
    @(posedge clk);
    #1;
    dmem_rd = 1'b1;
    dmem_addr = 32'h0000_0900;
    dmem_size = 3'b010;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    dmem_rd = 1'b0;
    @(negedge clk);
    chk("post_reset_req_valid", {31'd0, bus_req_valid}, 32'd0);
    chk("post_reset_data", dmem_data_in, 32'd0);
    chk("post_reset_err", {30'd0, misalign, bus_err}, 32'd0);
    access(1'b1, 1'b0, 32'h0000_0400, 3'b010, 32'h0,        32'hDEAD_BEEF, 0, 1'b1, 1'b1, 32'h0000_0400, 4'b0000, 32'h0,        32'hDEAD_BEEF, 1'b0, 1'b0, 3);

    repeat (3) @(negedge clk);
    if (bq.size() != 0 || dq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL leftover_expectations: got %0d bus and %0d completion pending expected 0",
               bq.size(), dq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
